nested_counter: RTL and testbench

NESTED_COUNTER -- requirements
Module: nested_counter

---
 rtl/nested_counter_pkg.sv | 32 +++
 rtl/counter_stage.sv | 49 ++++
 rtl/nested_counter.sv | 90 +++++++++
 tb/tb_nested_counter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nested_counter_pkg.sv
// Shared types for the nested counter: FSM state and per-level
// configuration record used between the top and its level stages.
package nested_counter_pkg;

    // Widest level the configuration record can carry.
    localparam int unsigned MAX_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic [MAX_BITS-1:0] start_v;
        logic [MAX_BITS-1:0] end_v;
        logic [MAX_BITS-1:0] step;
    } level_cfg_t;

    function automatic level_cfg_t make_cfg(
        input logic [MAX_BITS-1:0] start_v,
        input logic [MAX_BITS-1:0] end_v,
        input logic [MAX_BITS-1:0] step
    );
        level_cfg_t c;
        c.start_v = start_v;
        c.end_v   = end_v;
        c.step    = step;
        return c;
    endfunction

endpackage

// File: rtl/counter_stage.sv
// One count level: latched configuration, step/wrap arithmetic
// and the registered wrap pulse.
module counter_stage
    import nested_counter_pkg::*;
#(
    parameter int unsigned Bits = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  level_cfg_t      cfg_i,
    input  logic            adv_i,
    output logic [Bits-1:0] count_o,
    output logic            wrap_now_o,
    output logic            wrap_o
);

    localparam int unsigned SumW = MAX_BITS + 1;

    level_cfg_t      cfg_q;
    logic [SumW-1:0] nxt;
    logic            ovf;
    logic            degen;

    assign nxt   = SumW'(count_o) + SumW'(cfg_q.step);
    // Anything at or above bit Bits means the level overflowed.
    assign ovf   = |(nxt >> Bits);
    assign degen = (cfg_q.step == '0) || (cfg_q.start_v >= cfg_q.end_v);

    assign wrap_now_o = degen || ovf || (nxt > SumW'(cfg_q.end_v));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q   <= '0;
            count_o <= '0;
            wrap_o  <= 1'b0;
        end else begin
            wrap_o <= adv_i & wrap_now_o;
            if (load_i) begin
                cfg_q   <= cfg_i;
                count_o <= cfg_i.start_v[Bits-1:0];
            end else if (adv_i) begin
                count_o <= wrap_now_o ? cfg_q.start_v[Bits-1:0]
                                      : nxt[Bits-1:0];
            end
        end
    end

endmodule

// File: rtl/nested_counter.sv
// Cascaded multi-level counter: level k steps when all inner
// levels wrap together; RUN/HALT control with optional one-shot.
module nested_counter
    import nested_counter_pkg::*;
#(
    parameter int unsigned Bits   = 8,
    parameter int unsigned Levels = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic                   one_shot_i,
    input  logic [Levels*Bits-1:0] start_val_i,
    input  logic [Levels*Bits-1:0] end_val_i,
    input  logic [Levels*Bits-1:0] count_by_i,
    input  logic                   assert_on_i,
    output logic [Levels*Bits-1:0] count_o,
    output logic [Levels-1:0]      wrap_o,
    output logic                   last_o,
    output logic                   done_o,
    output logic                   busy_o
);

    state_e            state_q;
    logic              one_shot_q;
    logic [Levels-1:0] wrap_now;
    logic [Levels-1:0] adv;
    logic              all_wrap;
    level_cfg_t        cfg [Levels];

    assign busy_o   = (state_q == ST_RUN);
    // clear_i takes priority: no advance on a reload cycle.
    assign adv[0]   = busy_o & en_i & ~clear_i;
    assign all_wrap = adv[Levels-1] & wrap_now[Levels-1];
    assign last_o   = busy_o & (&wrap_now);

    for (genvar k = 0; k < Levels; k++) begin : g_lvl
        if (k > 0) begin : g_carry
            assign adv[k] = adv[k-1] & wrap_now[k-1];
        end

        assign cfg[k] = make_cfg(
            MAX_BITS'(start_val_i[k*Bits +: Bits]),
            MAX_BITS'(end_val_i[k*Bits +: Bits]),
            MAX_BITS'(count_by_i[k*Bits +: Bits])
        );

        counter_stage #(
            .Bits(Bits)
        ) u_stage (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .load_i    (clear_i),
            .cfg_i     (cfg[k]),
            .adv_i     (adv[k]),
            .count_o   (count_o[k*Bits +: Bits]),
            .wrap_now_o(wrap_now[k]),
            .wrap_o    (wrap_o[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            one_shot_q <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= all_wrap;
            if (clear_i) begin
                state_q    <= ST_RUN;
                one_shot_q <= one_shot_i;
            end else if (all_wrap && one_shot_q) begin
                state_q <= ST_HALT;
            end
        end
    end

    // Simulation-only sanity check of a configuration being loaded.
    always @(posedge clk_i) begin
        if (assert_on_i && clear_i) begin
            for (int k = 0; k < Levels; k++) begin
                assert (count_by_i[k*Bits +: Bits] != '0 &&
                        start_val_i[k*Bits +: Bits] <= end_val_i[k*Bits +: Bits])
                else $error("nested_counter: bad config on level %0d", k);
            end
        end
    end

endmodule

// File: tb/tb_nested_counter.sv
// Bench for nested_counter: fixed vector table, hand sequences and
// randomized traffic against a behavioural model.
module tb_nested_counter;

    localparam int unsigned B    = 8;
    localparam int unsigned L    = 3;
    localparam int unsigned W    = B * L;
    localparam int          MAXV = (1 << B) - 1;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         en_i, clear_i, one_shot_i, assert_on_i;
    logic [W-1:0] start_val_i, end_val_i, count_by_i;
    logic [W-1:0] count_o;
    logic [L-1:0] wrap_o;
    logic         last_o, done_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    nested_counter #(
        .Bits  (B),
        .Levels(L)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .clear_i    (clear_i),
        .one_shot_i (one_shot_i),
        .start_val_i(start_val_i),
        .end_val_i  (end_val_i),
        .count_by_i (count_by_i),
        .assert_on_i(assert_on_i),
        .count_o    (count_o),
        .wrap_o     (wrap_o),
        .last_o     (last_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt [L];
    int          m_st  [L];
    int          m_end [L];
    int          m_step[L];
    bit          m_os;
    int          m_state;  // 0 idle, 1 run, 2 halt
    logic [L-1:0] m_wrap;
    bit          m_done;

    function automatic void model_reset();
        for (int k = 0; k < L; k++) begin
            m_cnt[k] = 0; m_st[k] = 0; m_end[k] = 0; m_step[k] = 0;
        end
        m_os = 0; m_state = 0; m_wrap = '0; m_done = 0;
    endfunction

    function automatic bit lvl_wraps(int k);
        int nx;
        nx = m_cnt[k] + m_step[k];
        return m_step[k] == 0 || m_st[k] >= m_end[k] ||
               nx > m_end[k] || nx > MAXV;
    endfunction

    function automatic void model_clock(bit en, bit clr);
        bit carry;
        m_wrap = '0;
        m_done = 0;
        if (clr) begin
            for (int k = 0; k < L; k++) begin
                m_st[k]   = int'(start_val_i[k*B +: B]);
                m_end[k]  = int'(end_val_i[k*B +: B]);
                m_step[k] = int'(count_by_i[k*B +: B]);
                m_cnt[k]  = m_st[k];
            end
            m_os    = one_shot_i;
            m_state = 1;
        end else if (m_state == 1 && en) begin
            carry = 1;
            for (int k = 0; k < L && carry; k++) begin
                if (lvl_wraps(k)) begin
                    m_cnt[k]  = m_st[k];
                    m_wrap[k] = 1'b1;
                end else begin
                    m_cnt[k] += m_step[k];
                    carry = 0;
                end
            end
            if (carry) begin
                m_done = 1;
                if (m_os) m_state = 2;
            end
        end
    endfunction

    function automatic bit m_last();
        bit all;
        all = (m_state == 1);
        for (int k = 0; k < L; k++) all &= lvl_wraps(k);
        return all;
    endfunction

    function automatic logic [W-1:0] m_vec();
        logic [W-1:0] v;
        for (int k = 0; k < L; k++) v[k*B +: B] = m_cnt[k][B-1:0];
        return v;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count_o), 32'(m_vec()));
        chk({tag, ".wrap"},  32'(wrap_o),  32'(m_wrap));
        chk({tag, ".done"},  32'(done_o),  32'(m_done));
        chk({tag, ".busy"},  32'(busy_o),  32'(m_state == 1));
        chk({tag, ".last"},  32'(last_o),  32'(m_last()));
    endtask

    task automatic cyc(input logic en, input logic clr, input string tag);
        en_i    = en;
        clear_i = clr;
        model_clock(en, clr);
        @(posedge clk_i);
        @(negedge clk_i);
        check_model(tag);
    endtask

    task automatic randomize_cfg();
        for (int k = 0; k < L; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                start_val_i[k*B +: B] = B'($urandom_range(200, 255));
                end_val_i[k*B +: B]   = B'($urandom_range(200, 255));
                count_by_i[k*B +: B]  = B'($urandom_range(0, 80));
            end else begin
                start_val_i[k*B +: B] = B'($urandom_range(0, 4));
                end_val_i[k*B +: B]   = B'($urandom_range(0, 7));
                count_by_i[k*B +: B]  = B'($urandom_range(0, 3));
            end
        end
        one_shot_i = 1'($urandom_range(0, 1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         en, clr, os;
        logic [W-1:0] sv, ev, sb;
        logic [W-1:0] cnt;
        logic [L-1:0] wr;
        logic         dn, bz, ls;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic en, logic clr, logic os,
                                logic [W-1:0] sv, logic [W-1:0] ev,
                                logic [W-1:0] sb, logic [W-1:0] cnt,
                                logic [L-1:0] wr, logic dn, logic bz,
                                logic ls);
        vec_t v;
        v.en = en; v.clr = clr; v.os = os;
        v.sv = sv; v.ev = ev; v.sb = sb;
        v.cnt = cnt; v.wr = wr; v.dn = dn; v.bz = bz; v.ls = ls;
        tbl.push_back(v);
    endfunction

    initial begin
        logic e, c;

        en_i = 0; clear_i = 0; one_shot_i = 0; assert_on_i = 0;
        start_val_i = '0; end_val_i = '0; count_by_i = '0;
        model_reset();

        #2 rst_ni = 1'b0;
        #1 check_model("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // A: ends {0,1,2}, step 1, free-running
        add(0,1,0, 24'h000000,24'h000102,24'h010101, 24'h000000,3'b000,0,1,0);
        add(1,0,0, 24'h000000,24'h000102,24'h010101, 24'h000001,3'b000,0,1,0);
        add(1,0,0, 24'h000000,24'h000102,24'h010101, 24'h000002,3'b000,0,1,0);
        add(1,0,0, 24'h000000,24'h000102,24'h010101, 24'h000100,3'b001,0,1,0);
        add(1,0,0, 24'h000000,24'h000102,24'h010101, 24'h000101,3'b000,0,1,0);
        add(1,0,0, 24'h000000,24'h000102,24'h010101, 24'h000102,3'b000,0,1,1);
        add(1,0,0, 24'h000000,24'h000102,24'h010101, 24'h000000,3'b111,1,1,0);
        add(0,0,1, 24'hFFFFFF,24'hFFFFFF,24'hFFFFFF, 24'h000000,3'b000,0,1,0);
        add(1,0,1, 24'h777777,24'h000000,24'h000000, 24'h000001,3'b000,0,1,0);
        // B: level 0 2..14 step 3
        add(0,1,0, 24'h000002,24'h09090E,24'h010103, 24'h000002,3'b000,0,1,0);
        add(1,0,0, 24'h000002,24'h09090E,24'h010103, 24'h000005,3'b000,0,1,0);
        add(1,0,0, 24'h000002,24'h09090E,24'h010103, 24'h000008,3'b000,0,1,0);
        add(1,0,0, 24'h000002,24'h09090E,24'h010103, 24'h00000B,3'b000,0,1,0);
        add(1,0,0, 24'h000002,24'h09090E,24'h010103, 24'h00000E,3'b000,0,1,0);
        add(1,0,0, 24'h000002,24'h09090E,24'h010103, 24'h000102,3'b001,0,1,0);
        // C: level 0 overflow wrap, then clear together with en
        add(0,1,0, 24'h0000F0,24'h0303FF,24'h010120, 24'h0000F0,3'b000,0,1,0);
        add(1,0,0, 24'h0000F0,24'h0303FF,24'h010120, 24'h0001F0,3'b001,0,1,0);
        add(1,0,0, 24'h0000F0,24'h0303FF,24'h010120, 24'h0002F0,3'b001,0,1,0);
        add(1,1,0, 24'h0000F0,24'h0303FF,24'h010120, 24'h0000F0,3'b000,0,1,0);
        // D: one-shot, ends {0,1,1}
        add(0,1,1, 24'h000000,24'h000101,24'h010101, 24'h000000,3'b000,0,1,0);
        add(1,0,1, 24'h000000,24'h000101,24'h010101, 24'h000001,3'b000,0,1,0);
        add(1,0,1, 24'h000000,24'h000101,24'h010101, 24'h000100,3'b001,0,1,0);
        add(1,0,1, 24'h000000,24'h000101,24'h010101, 24'h000101,3'b000,0,1,1);
        add(1,0,1, 24'h000000,24'h000101,24'h010101, 24'h000000,3'b111,1,0,0);
        add(1,0,1, 24'h000000,24'h000101,24'h010101, 24'h000000,3'b000,0,0,0);
        add(1,0,1, 24'h000000,24'h000101,24'h010101, 24'h000000,3'b000,0,0,0);
        add(0,1,1, 24'h000000,24'h000101,24'h010101, 24'h000000,3'b000,0,1,0);
        add(1,0,1, 24'h000000,24'h000101,24'h010101, 24'h000001,3'b000,0,1,0);

        assert_on_i = 1'b1;
        foreach (tbl[i]) begin
            en_i = tbl[i].en; clear_i = tbl[i].clr; one_shot_i = tbl[i].os;
            start_val_i = tbl[i].sv; end_val_i = tbl[i].ev;
            count_by_i = tbl[i].sb;
            @(posedge clk_i);
            @(negedge clk_i);
            chk($sformatf("vec%0d.count", i), 32'(count_o), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.wrap", i),  32'(wrap_o),  32'(tbl[i].wr));
            chk($sformatf("vec%0d.done", i),  32'(done_o),  32'(tbl[i].dn));
            chk($sformatf("vec%0d.busy", i),  32'(busy_o),  32'(tbl[i].bz));
            chk($sformatf("vec%0d.last", i),  32'(last_o),  32'(tbl[i].ls));
        end
        assert_on_i = 1'b0;

        // en 5 on / 5 off, then clear with en
        start_val_i = '0; end_val_i = '1; count_by_i = 24'h010101;
        one_shot_i = 0;
        cyc(0, 1, "toggle");
        repeat (5) cyc(1, 0, "toggle");
        chk("toggle.five", 32'(count_o[B-1:0]), 32'd5);
        repeat (5) begin
            cyc(0, 0, "toggle");
            chk("toggle.hold", 32'(count_o[B-1:0]), 32'd5);
        end
        cyc(1, 1, "clr_en");
        chk("clr_en.wrap", 32'(wrap_o), 32'd0);

        // asynchronous reset mid-count
        repeat (3) cyc(1, 0, "pre_rst");
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst.count", 32'(count_o), 32'd0);
        chk("rst.busy",  32'(busy_o),  32'd0);
        chk("rst.done",  32'(done_o),  32'd0);
        chk("rst.wrap",  32'(wrap_o),  32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) cyc(1, 0, "post_rst");
        cyc(0, 1, "post_rst");
        cyc(1, 0, "post_rst");

        // randomized traffic; config pins churn without clear too
        randomize_cfg();
        cyc(0, 1, "rand");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) randomize_cfg();
            e = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 39) == 0);
            cyc(e, c, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
